// File: rtl/clock_disp_pkg.sv
// +--------------------------------------------------------------------+
// | clock_disp_pkg : segment patterns and BCD decode shared by display |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package clock_disp_pkg;

  // Active-high patterns, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] digit_idx_t;

  // Non-BCD codes show a dash so an out-of-range counter is visible
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// +--------------------------------------------------------------------+
// | seven_seg_decoder : BCD nibble to active-high 7-seg pattern        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module seven_seg_decoder
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : bcd_to_seg(bcd);
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
// +--------------------------------------------------------------------+
// | seven_seg_scan_driver : 4-digit multiplexed 7-seg driver with      |
// | frame snapshots, blink, leading-zero blank and anode dead time.    |
// | Optional macro COLON_BLINK_EN enables the blinking colon on dp_o.  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module seven_seg_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_i,
  input  logic [3:0]  blink_mask,
  input  logic        pause,
  input  logic        blank_lz,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int SLOT_W  = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  logic [SLOT_W-1:0]  slot_cnt;
  digit_idx_t         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               first_cyc;
  logic [15:0]        snapshot;

  logic       slot_wrap;
  logic       blink_wrap;
  logic       load_snap;
  logic [3:0] eff_mask;
  logic [3:0] cur_digit;
  logic       blink_blank;
  logic       lz_blank;
  logic [3:0] an_dec;
  logic [6:0] seg_dec;
  logic       dp_act;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  // A new frame is latched right after reset and whenever digit 3 hands back to digit 0
  assign load_snap  = first_cyc | (slot_wrap & (idx == 2'd3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      first_cyc   <= 1'b1;
      snapshot    <= '0;
    end else begin
      first_cyc <= 1'b0;
      slot_cnt  <= slot_wrap ? '0 : slot_cnt + SLOT_ONE;
      if (slot_wrap) begin
        idx <= idx + 2'd1;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_ONE;
      if (blink_wrap) begin
        blink_phase <= ~blink_phase;
      end
      if (load_snap) begin
        snapshot <= digits_i;
      end
    end
  end

  always_comb begin
    eff_mask    = pause ? 4'hF : blink_mask;
    cur_digit   = snapshot[{idx, 2'b00} +: 4];
    blink_blank = eff_mask[idx] & ~blink_phase;
    lz_blank    = blank_lz & (idx == 2'd3) & (cur_digit == 4'd0);
    // Slot count 0 keeps every anode off so the previous digit cannot ghost
    an_dec      = (slot_cnt == '0) ? 4'b0000 : (4'b0001 << idx);
  end

  seven_seg_decoder u_decoder (
    .bcd   (cur_digit),
    .blank (blink_blank | lz_blank),
    .seg   (seg_dec)
  );

`ifdef COLON_BLINK_EN
  assign dp_act = (idx == 2'd2) & (blink_phase | pause);
`else
  assign dp_act = 1'b0;
`endif

  // Polarity is applied only here; everything upstream is active-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_o   <= {7{SEG_ACTIVE_LOW}};
      dp_o    <= SEG_ACTIVE_LOW;
      an_o    <= {4{SEG_ACTIVE_LOW}};
      frame_o <= 1'b0;
    end else begin
      seg_o   <= seg_dec ^ {7{SEG_ACTIVE_LOW}};
      dp_o    <= dp_act ^ SEG_ACTIVE_LOW;
      an_o    <= an_dec ^ {4{SEG_ACTIVE_LOW}};
      frame_o <= load_snap;
    end
  end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Downstream consumer of the four BCD digit counters (hours tens/units, minutes tens/units).
- Time-multiplexes the four digits onto one 4-digit common-anode 7-segment display.
- Provides tear-free frame snapshots, per-digit blink for set mode, leading-zero blanking and anti-ghost dead time.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit slot lasts (min 2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (min 1).
- SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o/an_o asserted low; 0: asserted high.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- digits_i  input  16  BCD nibbles; [3:0] min units, [7:4] min tens, [11:8] hr units, [15:12] hr tens.
- blink_mask  input  4  bit i set: digit i blinks.
- pause  input  1  clock paused; all digits blink.
- blank_lz  input  1  blank digit 3 when its value is 0.
- seg_o  output  7  segments, [0]=a .. [6]=g.
- dp_o  output  1  decimal point / colon.
- an_o  output  4  digit anode enables, [i]=digit i.
- frame_o  output  1  one-cycle pulse at each snapshot.

Behaviour:
- Reset (asynchronous, while reset=0):
  - slot counter=0, scan index=0, blink counter=0, blink_phase=1 (visible), snapshot=0.
  - seg_o, dp_o, an_o all inactive; frame_o=0.
- Slot counter counts 0..REFRESH_DIV-1 and wraps. On wrap, index advances 0->1->2->3->0.
- Snapshot:
  - digits_i is registered into the snapshot on the first cycle after reset release, and on every cycle where the index wraps 3->0.
  - frame_o pulses on that same cycle.
  - Mid-frame changes on digits_i are not shown until the next frame.
- Outputs are registered: seg_o/an_o reflect the new index one clk after the index changes.
- Dead time: an_o is all inactive during slot count 0 of every slot. Exactly one anode is active for counts 1..REFRESH_DIV-1.
- Decode:
  - Values 0-9 use standard patterns (0 = a,b,c,d,e,f).
  - Values 10-15 display a dash (g only). This marks a counter transiently out of range.
- Blink:
  - blink_phase toggles every BLINK_DIV cycles.
  - Effective mask = pause ? 4'hF : blink_mask.
  - Digit i is blanked (segments off, anode still scanned) when mask[i]=1 and blink_phase=0.
- Leading-zero blanking: when blank_lz=1 and snapshot digit 3 == 0, digit 3 segments are off. Blanking is checked per slot against the snapshot, not the live input.
- Blank priority: blink blank or LZ blank → segments off; otherwise the decode result.
- dp_o is inactive unless COLON_BLINK_EN is defined.
- Polarity: the SEG_ACTIVE_LOW inversion is applied at the output registers only. Internal logic is active-high.
- Reset mid-frame: everything returns to reset values immediately. Scanning restarts at digit 0 with a fresh snapshot.
- Simultaneous events:
  - A blink toggle and a slot wrap in the same cycle both take effect; the next registered output uses the new phase.
  - pause does not stop scanning or the blink counter.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined:
  - dp_o is active while digit 2 (hr units) is scanned and blink_phase=1, giving a blinking colon.
  - When pause=1, dp_o is active steadily during digit 2.
- Undefined: dp_o is tied inactive and the dp logic is absent.

Decomposition:
- Package clock_disp_pkg:
  - segment pattern constants: SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - digit index typedef (2-bit);
  - function bcd_to_seg.
- Sub-module seven_seg_decoder: combinational 4-bit BCD to 7-bit pattern with blank input; instantiated once on the muxed digit.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16, SEG_ACTIVE_LOW=0):
- Release reset with digits_i=16'h1234 → frame_o pulses once. an_o cycles 0000,0001×3, 0000,0010×3, 0000,0100×3, 0000,1000×3. seg_o shows 4,3,2,1 in slot order (4 = 7'b1100110).
- Change digits_i to 16'h5678 at the midpoint of slot 1 → the remainder of the frame still shows 3,2,1. The next frame shows 8,7,6,5, starting at the frame_o pulse.
- blink_mask=4'b0011, digits 16'h1234 → digits 0 and 1 have segments off for 16 cycles and on for 16 cycles. Digits 2 and 3 are never blanked. an_o is unchanged.
- pause=1 → all four digits blank in alternate 16-cycle windows. Scanning continues.
- digits_i=16'h0A59 with blank_lz=1 → digit 3 off, digit 2 shows dash (7'b1000000). With blank_lz=0 → digit 3 shows 0 (7'b0111111).
- Assert reset mid-slot 2 → seg_o/an_o go inactive within the same cycle, without waiting for clk. After release, scanning restarts at an_o=0001 following a dead cycle, from a fresh snapshot.
